// File: rtl/program_counter_pkg.sv
// Shared constants, select/state encodings and next-PC select decode for the fetch-address register.
package program_counter_pkg;

    localparam int unsigned PC_WIDTH = 8;
    localparam int unsigned PC_STEP  = 1;
    localparam logic [PC_WIDTH-1:0] PC_RESET_VECTOR = 8'h00;

    typedef enum logic [1:0] {
        SEL_INC  = 2'd0,
        SEL_HOLD = 2'd1,
        SEL_BR   = 2'd2
    } pc_sel_e;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } pc_state_e;

    // Branch beats stall; BOOT ignores both so the first fetch is the reset vector.
    function automatic pc_sel_e pc_select(pc_state_e state, logic stall, logic br_en);
        pc_sel_e sel;
        sel = SEL_INC;
        if (state == ST_BOOT) begin
            sel = SEL_HOLD;
        end else if (br_en) begin
            sel = SEL_BR;
        end else if (stall) begin
            sel = SEL_HOLD;
        end
        return sel;
    endfunction

endpackage

// File: rtl/program_counter_if.sv
// Fetch-control bus: the master drives stall/branch requests, the slave returns the fetch address.
interface program_counter_if
    import program_counter_pkg::*;
#(
    parameter int unsigned WIDTH = PC_WIDTH
);
    logic             stall;
    logic             br_en;
    logic [WIDTH-1:0] br_target;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus;
    logic             pc_valid;

    modport master (
        output stall,
        output br_en,
        output br_target,
        input  pc,
        input  pc_plus,
        input  pc_valid
    );

    modport slave (
        input  stall,
        input  br_en,
        input  br_target,
        output pc,
        output pc_plus,
        output pc_valid
    );
endinterface

// File: rtl/program_counter_bit_cell.sv
// One PC bit: 3:1 select mux into a rising-edge flop whose async init value is RV_BIT.
module program_counter_bit_cell
    import program_counter_pkg::*;
#(
    parameter bit RV_BIT = 1'b0
) (
    input  logic    clk,
    input  logic    rst_n,
    input  pc_sel_e sel,
    input  logic    d_inc,
    input  logic    d_br,
    output logic    q
);

    logic d;

    always_comb begin
        d = q;
        case (sel)
            SEL_INC: d = d_inc;
            SEL_BR:  d = d_br;
            default: d = q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RV_BIT;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/program_counter.sv
// Fetch-address register: BOOT/RUN state cell, select decode, half-adder STEP incrementer, per-bit cells.
module program_counter
    import program_counter_pkg::*;
#(
    parameter int unsigned       WIDTH        = PC_WIDTH,
    parameter int unsigned       STEP         = PC_STEP,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = WIDTH'(PC_RESET_VECTOR)
) (
    input  logic              clk,
    input  logic              rst_n,
    program_counter_if.slave  bus
);

    localparam int unsigned STEP_LSB = $clog2(STEP);

    pc_state_e        state;
    logic             pc_valid_q;
    pc_sel_e          sel;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] carry;

    // BOOT lasts exactly one edge after reset release; RUN is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_BOOT;
            pc_valid_q <= 1'b0;
        end else begin
            state      <= ST_RUN;
            pc_valid_q <= 1'b1;
        end
    end

    assign sel = pc_select(state, bus.stall, bus.br_en);

    // Bits below STEP_LSB pass through; the chain starts with a forced carry at STEP_LSB.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_inc
        if (i == int'(STEP_LSB)) begin : g_seed
            assign carry[i] = 1'b1;
        end else if (i == 0) begin : g_zero
            assign carry[i] = 1'b0;
        end else begin : g_chain
            assign carry[i] = pc_q[i-1] & carry[i-1];
        end
        assign pc_inc[i] = pc_q[i] ^ carry[i];
    end

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        program_counter_bit_cell #(
            .RV_BIT (RESET_VECTOR[i])
        ) u_bit (
            .clk   (clk),
            .rst_n (rst_n),
            .sel   (sel),
            .d_inc (pc_inc[i]),
            .d_br  (bus.br_target[i]),
            .q     (pc_q[i])
        );
    end

    assign bus.pc       = pc_q;
    assign bus.pc_plus  = pc_inc;
    assign bus.pc_valid = pc_valid_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter: reference model, per-cycle compare, and literal spot checks.
module tb_program_counter;

    localparam int unsigned W    = 8;
    localparam int unsigned STEP = 1;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    bit   checking;

    logic [W-1:0] m_pc;
    logic         m_valid;

    program_counter_if #(.WIDTH(W)) bus ();

    program_counter #(
        .WIDTH        (W),
        .STEP         (STEP),
        .RESET_VECTOR (8'h00)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the spec's next-PC rules as plain arithmetic.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc    = 8'h00;
            m_valid = 1'b0;
        end else if (!m_valid) begin
            m_valid = 1'b1;
        end else if (bus.br_en) begin
            m_pc = bus.br_target;
        end else if (!bus.stall) begin
            m_pc = W'((int'(m_pc) + int'(STEP)) % 256);
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            check("model_pc", bus.pc, m_pc);
            check("model_valid", W'(bus.pc_valid), W'(m_valid));
            check("model_pc_plus", bus.pc_plus, W'((int'(m_pc) + int'(STEP)) % 256));
        end
    end

    task automatic drive(input logic s, input logic b, input logic [W-1:0] t);
        bus.stall     = s;
        bus.br_en     = b;
        bus.br_target = t;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        checking      = 1'b0;
        m_pc          = 8'h00;
        m_valid       = 1'b0;
        bus.stall     = 1'b0;
        bus.br_en     = 1'b0;
        bus.br_target = 8'h00;
        rst_n         = 1'b1;
        #1 rst_n = 1'b0;
        checking = 1'b1;

        // Test 1: reset held 3 cycles, then BOOT and first increment.
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        check("t1_rel_pc", bus.pc, 8'h00);
        check("t1_rel_valid", W'(bus.pc_valid), 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        check("t1_boot_pc", bus.pc, 8'h00);
        check("t1_boot_valid", W'(bus.pc_valid), 8'h01);
        drive(1'b0, 1'b0, 8'h00);
        check("t1_inc_pc", bus.pc, 8'h01);

        // Test 2: wrap through 0xFF.
        drive(1'b0, 1'b1, 8'hFD);
        check("t2_load", bus.pc, 8'hFD);
        drive(1'b0, 1'b0, 8'h00);
        check("t2_fe", bus.pc, 8'hFE);
        drive(1'b0, 1'b0, 8'h00);
        check("t2_ff", bus.pc, 8'hFF);
        check("t2_plus_wrap", bus.pc_plus, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        check("t2_00", bus.pc, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        check("t2_01", bus.pc, 8'h01);

        // Test 3: stall holds.
        drive(1'b0, 1'b1, 8'h10);
        check("t3_load", bus.pc, 8'h10);
        drive(1'b1, 1'b0, 8'h00);
        check("t3_stall1", bus.pc, 8'h10);
        drive(1'b1, 1'b0, 8'h00);
        check("t3_stall2", bus.pc, 8'h10);
        check("t3_plus", bus.pc_plus, 8'h11);
        drive(1'b0, 1'b0, 8'h00);
        check("t3_resume", bus.pc, 8'h11);

        // Test 4: branch overrides stall.
        drive(1'b0, 1'b1, 8'h20);
        check("t4_load", bus.pc, 8'h20);
        drive(1'b1, 1'b1, 8'h80);
        check("t4_branch", bus.pc, 8'h80);
        drive(1'b0, 1'b0, 8'h00);
        check("t4_inc", bus.pc, 8'h81);

        // Test 5: async reset mid-cycle with a branch pending.
        drive(1'b0, 1'b1, 8'h42);
        check("t5_load", bus.pc, 8'h42);
        bus.br_target = 8'h99;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_pc", bus.pc, 8'h00);
        check("t5_async_valid", W'(bus.pc_valid), 8'h00);
        #1 rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("t5_rel_pc", bus.pc, 8'h00);
        check("t5_rel_valid", W'(bus.pc_valid), 8'h00);

        // Test 6: branch ignored in BOOT, then normal run resumes.
        drive(1'b0, 1'b1, 8'h55);
        check("t6_boot_pc", bus.pc, 8'h00);
        check("t6_boot_valid", W'(bus.pc_valid), 8'h01);
        drive(1'b0, 1'b0, 8'h00);
        check("t6_inc1", bus.pc, 8'h01);
        drive(1'b0, 1'b0, 8'h00);
        check("t6_inc2", bus.pc, 8'h02);

        // Extra: branch to top of range then wrap under a single stall.
        drive(1'b0, 1'b1, 8'hFF);
        check("x_load_ff", bus.pc, 8'hFF);
        drive(1'b1, 1'b0, 8'h00);
        check("x_stall_ff", bus.pc, 8'hFF);
        drive(1'b0, 1'b0, 8'h00);
        check("x_wrap", bus.pc, 8'h00);

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
